// File: rtl/m_tx_frame_arb.sv
// Transmit arbiter for the UART command link. It round-robins two requesters and streams
// a 9-byte response frame (header, len, cmd, four param bytes, checksum, tail) to UART TX.
module m_tx_frame_arb #(
  parameter logic [7:0] HEADER = 8'h40,
  parameter logic [7:0] TAIL   = 8'hBC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [7:0]  i_cmd0,
  input  logic [7:0]  i_cmd1,
  input  logic [31:0] i_para0,
  input  logic [31:0] i_para1,
  output logic [1:0]  o_gnt,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_frame_cnt
);

  localparam logic [7:0] LEN      = 8'h05;
  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Two's-complement checksum so that LEN..P0 plus CHK sums to zero modulo 256.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] para);
    logic [7:0] sum;
    sum = LEN + cmd + para[31:24] + para[23:16] + para[15:8] + para[7:0];
    return (~sum) + 8'd1;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [7:0]  cmd,
                                            input logic [31:0] para);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = LEN;
      4'd2:    b = cmd;
      4'd3:    b = para[31:24];
      4'd4:    b = para[23:16];
      4'd5:    b = para[15:8];
      4'd6:    b = para[7:0];
      4'd7:    b = frame_chk(cmd, para);
      4'd8:    b = TAIL;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] para_q, para_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        win_s;
  logic        accept_s;

  assign accept_s = tx_valid_q & i_tx_ready;

  // A lone request wins outright; a tie goes to the requester not served last.
  always_comb begin
    win_s = 1'b0;
    if (i_req == 2'b10) begin
      win_s = 1'b1;
    end else if (i_req == 2'b11) begin
      win_s = ~last_q;
    end else begin
      win_s = 1'b0;
    end
  end

  // Frame sequencing: grant and capture in IDLE, then advance one byte per accepted handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    cmd_d       = cmd_q;
    para_d      = para_q;
    gnt_d       = 2'b00;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req != 2'b00) begin
          state_d    = S_SEND;
          idx_d      = 4'd0;
          last_d     = win_s;
          cmd_d      = win_s ? i_cmd1 : i_cmd0;
          para_d     = win_s ? i_para1 : i_para0;
          gnt_d      = win_s ? 2'b10 : 2'b01;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept_s && (idx_q == LAST_IDX)) begin
          state_d     = S_IDLE;
          idx_d       = 4'd0;
          tx_valid_d  = 1'b0;
          tx_data_d   = 8'h00;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (accept_s) begin
          idx_d     = idx_q + 4'd1;
          tx_data_d = frame_byte(idx_q + 4'd1, cmd_q, para_q);
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d    = S_IDLE;
        idx_d      = 4'd0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      last_q      <= 1'b1;
      cmd_q       <= 8'h00;
      para_q      <= 32'h0000_0000;
      gnt_q       <= 2'b00;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      para_q      <= para_d;
      gnt_q       <= gnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = tx_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_m_tx_frame_arb.sv
// Self-checking bench for m_tx_frame_arb: randomized requests and backpressure checked
// against a frame/arbitration model built directly from the frame format rules.
module tb_m_tx_frame_arb;

  typedef logic [8:0][7:0] frame_t;

  logic        clk;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [7:0]  i_cmd0, i_cmd1;
  logic [31:0] i_para0, i_para1;
  logic [1:0]  o_gnt;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_frame_cnt;

  int checks   = 0;
  int failures = 0;
  int model_last;
  int model_cnt;

  m_tx_frame_arb dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_cmd0      (i_cmd0),
    .i_cmd1      (i_cmd1),
    .i_para0     (i_para0),
    .i_para1     (i_para1),
    .o_gnt       (o_gnt),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_frame_cnt (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame from the byte layout; checksum is the value that makes the sum 0 mod 256.
  function automatic frame_t exp_frame(input logic [7:0] cmd, input logic [31:0] para);
    frame_t f;
    int s;
    int c;
    s = 5 + int'(cmd) + int'(para[31:24]) + int'(para[23:16]) + int'(para[15:8]) + int'(para[7:0]);
    c = (256 - (s % 256)) % 256;
    f[0] = 8'h40;
    f[1] = 8'h05;
    f[2] = cmd;
    f[3] = para[31:24];
    f[4] = para[23:16];
    f[5] = para[15:8];
    f[6] = para[7:0];
    f[7] = 8'(c);
    f[8] = 8'hBC;
    return f;
  endfunction

  function automatic int model_pick(input logic [1:0] req);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return (model_last == 0) ? 1 : 0;
  endfunction

  // Waits for a grant, then records each accepted byte while driving i_tx_ready randomly.
  task automatic collect_frame(input int rdy_pct, input logic chg, input logic [31:0] new_para,
                               output frame_t b, output logic [1:0] g, output int wait_cyc,
                               output int cyc, output int viol, output logic end_ok,
                               output logic [15:0] cnt_after);
    int n;
    logic [7:0] prev_d;
    b = '0; g = 2'b00; wait_cyc = 0; cyc = 0; viol = 0; end_ok = 1'b0; cnt_after = 16'h0;
    n = 0;
    while (o_gnt === 2'b00 && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    g = o_gnt;
    if (g === 2'b00) return;
    if (chg) begin
      i_para0 = new_para;
      i_para1 = new_para;
    end
    while (n < 9 && cyc < 300) begin
      i_tx_ready = (int'($urandom_range(99)) < rdy_pct);
      prev_d = o_tx_data;
      if (o_tx_valid !== 1'b1 || o_busy !== 1'b1) viol++;
      @(posedge clk); #1;
      cyc++;
      if (o_gnt !== 2'b00) viol++;
      if (i_tx_ready) begin
        b[n] = prev_d;
        n++;
      end else if (o_tx_data !== prev_d || o_tx_valid !== 1'b1) begin
        viol++;
      end
    end
    end_ok = (o_done === 1'b1) && (o_tx_valid === 1'b0) && (o_busy === 1'b0);
    cnt_after = o_frame_cnt;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_gnt !== 2'b00 || o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_tx gnt=%b valid=%b data=%h required 00/0/00", o_gnt, o_tx_valid, o_tx_data);
    end
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_frame_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_status busy=%b done=%b cnt=%h required 0/0/0000", o_busy, o_done, o_frame_cnt);
    end
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_last = 1;
    model_cnt = 0;
  endtask

  task automatic test_single();
    frame_t b, e;
    logic [1:0] g;
    int w, cyc, viol;
    logic eok;
    logic [15:0] cnt;
    i_cmd0 = 8'h01;
    i_para0 = 32'h11223344;
    i_tx_ready = 1'b1;
    i_req = 2'b01;
    collect_frame(100, 1'b0, 32'h0, b, g, w, cyc, viol, eok, cnt);
    i_req = 2'b00;
    model_last = model_pick(2'b01);
    model_cnt++;
    e = exp_frame(8'h01, 32'h11223344);
    checks++;
    if (g !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b required=01", g); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (b[i] !== e[i]) begin failures++; $display("FAIL single_byte%0d got=%h required=%h", i, b[i], e[i]); end
    end
    checks++;
    if (cyc !== 9 || viol !== 0) begin failures++; $display("FAIL single_timing cycles=%0d viol=%0d required 9/0", cyc, viol); end
    checks++;
    if (eok !== 1'b1 || cnt !== 16'(model_cnt)) begin
      failures++; $display("FAIL single_end end_ok=%b cnt=%0d required 1/%0d", eok, cnt, model_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (o_done !== 1'b0 || o_gnt !== 2'b00 || o_busy !== 1'b0) begin
      failures++; $display("FAIL single_idle done=%b gnt=%b busy=%b required 0/00/0", o_done, o_gnt, o_busy);
    end
  endtask

  task automatic test_alternate();
    frame_t b, e;
    logic [1:0] g;
    int w, cyc, viol, ew;
    logic eok;
    logic [15:0] cnt;
    i_rst = 1'b1; #2; i_rst = 1'b0;
    model_last = 1;
    model_cnt = 0;
    i_cmd1 = 8'hA5;
    i_para1 = 32'h0;
    i_cmd0 = 8'($urandom);
    i_para0 = $urandom;
    i_tx_ready = 1'b1;
    i_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e = (model_pick(2'b11) == 1) ? exp_frame(i_cmd1, i_para1) : exp_frame(i_cmd0, i_para0);
      collect_frame(100, 1'b0, 32'h0, b, g, w, cyc, viol, eok, cnt);
      ew = model_pick(2'b11);
      model_last = ew;
      model_cnt++;
      checks++;
      if (g !== ((ew == 1) ? 2'b10 : 2'b01) || w !== 1) begin
        failures++; $display("FAIL alt%0d_gnt got=%b wait=%0d required winner=%0d wait=1", k, g, w, ew);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (b[i] !== e[i]) begin failures++; $display("FAIL alt%0d_byte%0d got=%h required=%h", k, i, b[i], e[i]); end
      end
      if (ew == 1) begin
        checks++;
        if (b[7] !== 8'h56) begin failures++; $display("FAIL alt%0d_chk_a5 got=%h required=56", k, b[7]); end
      end
      checks++;
      if (viol !== 0 || eok !== 1'b1 || cnt !== 16'(model_cnt)) begin
        failures++; $display("FAIL alt%0d_end viol=%0d end_ok=%b cnt=%0d required 0/1/%0d", k, viol, eok, cnt, model_cnt);
      end
      i_cmd0 = 8'($urandom);
      i_para0 = $urandom;
    end
    i_req = 2'b00;
  endtask

  task automatic test_backpressure();
    frame_t b, e;
    logic [1:0] g, rq;
    int w, cyc, viol, ew;
    logic eok;
    logic [15:0] cnt;
    for (int k = 0; k < 4; k++) begin
      i_cmd0 = 8'($urandom);
      i_para0 = $urandom;
      i_cmd1 = 8'($urandom);
      i_para1 = $urandom;
      rq = 2'(1 + $urandom_range(2));
      ew = model_pick(rq);
      e = (ew == 1) ? exp_frame(i_cmd1, i_para1) : exp_frame(i_cmd0, i_para0);
      i_req = rq;
      collect_frame(45, 1'b0, 32'h0, b, g, w, cyc, viol, eok, cnt);
      i_req = 2'b00;
      model_last = ew;
      model_cnt++;
      checks++;
      if (g !== ((ew == 1) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL bp%0d_gnt got=%b required winner=%0d (req=%b)", k, g, ew, rq);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (b[i] !== e[i]) begin failures++; $display("FAIL bp%0d_byte%0d got=%h required=%h", k, i, b[i], e[i]); end
      end
      checks++;
      if (viol !== 0 || eok !== 1'b1 || cnt !== 16'(model_cnt)) begin
        failures++; $display("FAIL bp%0d_end viol=%0d end_ok=%b cnt=%0d required 0/1/%0d", k, viol, eok, cnt, model_cnt);
      end
    end
  endtask

  task automatic test_checksum_wrap();
    frame_t b, e;
    logic [1:0] g;
    int w, cyc, viol;
    logic eok;
    logic [15:0] cnt;
    i_cmd0 = 8'hFF;
    i_para0 = 32'hFFFF_FFFF;
    i_req = 2'b01;
    collect_frame(100, 1'b0, 32'h0, b, g, w, cyc, viol, eok, cnt);
    i_req = 2'b00;
    model_last = model_pick(2'b01);
    model_cnt++;
    e = exp_frame(8'hFF, 32'hFFFF_FFFF);
    checks++;
    if (b[7] !== 8'h00) begin failures++; $display("FAIL wrap_chk got=%h required=00", b[7]); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (b[i] !== e[i]) begin failures++; $display("FAIL wrap_byte%0d got=%h required=%h", i, b[i], e[i]); end
    end
  endtask

  task automatic test_input_change();
    frame_t b, e;
    logic [1:0] g;
    int w, cyc, viol;
    logic eok;
    logic [15:0] cnt;
    logic [31:0] p;
    p = $urandom;
    i_cmd0 = 8'($urandom);
    i_para0 = p;
    e = exp_frame(i_cmd0, p);
    i_req = 2'b01;
    collect_frame(70, 1'b1, ~p, b, g, w, cyc, viol, eok, cnt);
    i_req = 2'b00;
    model_last = model_pick(2'b01);
    model_cnt++;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (b[i] !== e[i]) begin failures++; $display("FAIL chg_byte%0d got=%h required=%h", i, b[i], e[i]); end
    end
    checks++;
    if (cnt !== 16'(model_cnt)) begin failures++; $display("FAIL chg_cnt got=%0d required=%0d", cnt, model_cnt); end
  endtask

  task automatic test_reset_mid();
    frame_t b, e;
    logic [1:0] g;
    int w, cyc, viol;
    logic eok;
    logic [15:0] cnt;
    i_rst = 1'b1; #2; i_rst = 1'b0;
    model_last = 1;
    model_cnt = 0;
    i_cmd0 = 8'($urandom);
    i_para0 = $urandom;
    e = exp_frame(i_cmd0, i_para0);
    i_tx_ready = 1'b1;
    i_req = 2'b01;
    w = 0;
    while (o_gnt === 2'b00 && w < 20) begin @(posedge clk); #1; w++; end
    checks++;
    if (o_gnt !== 2'b01) begin failures++; $display("FAIL mid_gnt got=%b required=01", o_gnt); end
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (o_tx_data !== e[5] || o_busy !== 1'b1) begin
      failures++; $display("FAIL mid_progress data=%h busy=%b required %h/1", o_tx_data, o_busy, e[5]);
    end
    i_req = 2'b11;
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 || o_busy !== 1'b0 || o_gnt !== 2'b00) begin
      failures++; $display("FAIL mid_async valid=%b data=%h busy=%b gnt=%b required 0/00/0/00", o_tx_valid, o_tx_data, o_busy, o_gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (o_done !== 1'b0 || o_frame_cnt !== 16'h0 || o_tx_valid !== 1'b0) begin
      failures++; $display("FAIL mid_hold done=%b cnt=%0d valid=%b required 0/0/0", o_done, o_frame_cnt, o_tx_valid);
    end
    i_rst = 1'b0;
    i_cmd0 = 8'($urandom);
    i_para0 = $urandom;
    e = exp_frame(i_cmd0, i_para0);
    collect_frame(100, 1'b0, 32'h0, b, g, w, cyc, viol, eok, cnt);
    i_req = 2'b00;
    model_last = model_pick(2'b11);
    model_cnt++;
    checks++;
    if (g !== 2'b01 || w !== 1) begin failures++; $display("FAIL mid_restart_gnt got=%b wait=%0d required 01/1", g, w); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (b[i] !== e[i]) begin failures++; $display("FAIL mid_restart_byte%0d got=%h required=%h", i, b[i], e[i]); end
    end
    checks++;
    if (eok !== 1'b1 || cnt !== 16'(model_cnt)) begin
      failures++; $display("FAIL mid_restart_end end_ok=%b cnt=%0d required 1/%0d", eok, cnt, model_cnt);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_req = 2'b00;
    i_cmd0 = 8'h00;
    i_cmd1 = 8'h00;
    i_para0 = 32'h0;
    i_para1 = 32'h0;
    i_tx_ready = 1'b0;
    model_last = 1;
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_checksum_wrap();
    test_input_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
